// File: rtl/perceptron_accum.sv
// Perceptron frame accumulator: sums 7-bit partial sums per frame, compares
// the total against a threshold captured on the first beat, and holds the result.
module perceptron_accum #(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_sum,
  input  logic        in_last,
  input  logic [10:0] threshold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_sum,
  output logic        out_fire,
  output logic        out_trunc,
  output logic [7:0]  frame_cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [4:0] LIMIT = 5'(MAX_BEATS);

  state_t      state, state_nx;
  logic [10:0] acc, acc_nx;
  logic [10:0] thr_q, thr_nx;
  logic [4:0]  beat_cnt, beat_nx;
  logic [10:0] sum_nx;
  logic        fire_nx, trunc_nx;
  logic [7:0]  frame_nx;
  logic        accept;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && (state == ACCUM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACCUM;
      acc       <= '0;
      thr_q     <= '0;
      beat_cnt  <= '0;
      out_sum   <= '0;
      out_fire  <= 1'b0;
      out_trunc <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      thr_q     <= thr_nx;
      beat_cnt  <= beat_nx;
      out_sum   <= sum_nx;
      out_fire  <= fire_nx;
      out_trunc <= trunc_nx;
      frame_cnt <= frame_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    thr_nx   = thr_q;
    beat_nx  = beat_cnt;
    sum_nx   = out_sum;
    fire_nx  = out_fire;
    trunc_nx = out_trunc;
    frame_nx = frame_cnt;

    if (accept) begin
      // A zero beat count marks the frame's first beat: reload, not add.
      if (beat_cnt == '0) begin
        acc_nx = {4'b0000, in_sum};
        thr_nx = threshold;
      end else begin
        acc_nx = acc + {4'b0000, in_sum};
      end
      beat_nx = beat_cnt + 5'd1;
      if (in_last || (beat_nx == LIMIT)) begin
        state_nx = HOLD;
        sum_nx   = acc_nx;
        fire_nx  = (acc_nx >= thr_nx);
        trunc_nx = !in_last;
        beat_nx  = '0;
      end
    end

    if ((state == HOLD) && out_ready) begin
      state_nx = ACCUM;
      frame_nx = frame_cnt + 8'd1;
    end
  end

endmodule
